lock_sequencer: RTL and testbench

//   Canal-lock controller that sequences the seconds countdown timer. Accepts boat

---
 rtl/lock_sequencer_if.sv | 31 +++
 rtl/lock_sequencer.sv | 139 +++++++++++++
 tb/tb_lock_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_sequencer_if.sv
// Signal bundle between the lock sequencer and its sensors, actuators and timer.
// master = sequencer side, slave = environment (sensors, gates, valves, timer).
interface lock_sequencer_if;
  logic       arrive_low;
  logic       arrive_high;
  logic       boat_in;
  logic       boat_out;
  logic       timer_done;
  logic [9:0] timer_secs;
  logic       timer_start;
  logic       gate_low_open;
  logic       gate_high_open;
  logic       fill_valve;
  logic       drain_valve;
  logic       level_high;
  logic       busy;
  logic       done;
  logic [2:0] state;

  modport master (
    input  arrive_low, arrive_high, boat_in, boat_out, timer_done,
    output timer_secs, timer_start, gate_low_open, gate_high_open,
           fill_valve, drain_valve, level_high, busy, done, state
  );

  modport slave (
    output arrive_low, arrive_high, boat_in, boat_out, timer_done,
    input  timer_secs, timer_start, gate_low_open, gate_high_open,
           fill_valve, drain_valve, level_high, busy, done, state
  );
endinterface

// File: rtl/lock_sequencer.sv
// Canal-lock controller: arbitrates boat arrivals at both gates and sequences
// gates, valves and the external seconds timer for each lockage.
module lock_sequencer #(
  parameter int FILL_SECS  = 420,
  parameter int DRAIN_SECS = 480
) (
  input  logic               clk,
  input  logic               reset,
  lock_sequencer_if.master   bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PREP_START = 3'd1;
  localparam logic [2:0] S_PREP_WAIT  = 3'd2;
  localparam logic [2:0] S_ENTER      = 3'd3;
  localparam logic [2:0] S_XFER_START = 3'd4;
  localparam logic [2:0] S_XFER_WAIT  = 3'd5;
  localparam logic [2:0] S_EXIT       = 3'd6;

  localparam logic [9:0] FILL_V  = 10'(FILL_SECS);
  localparam logic [9:0] DRAIN_V = 10'(DRAIN_SECS);

  logic [2:0] r_state;
  logic       r_level_high;
  logic       r_dir;
  logic       r_req_low;
  logic       r_req_high;
  logic       r_done;

  logic [2:0] w_state_next;
  logic       w_level_next;
  logic       w_dir_next;
  logic       w_done_next;
  logic       w_pick_high;
  logic       w_eff_low;
  logic       w_eff_high;
  logic       w_enter;
  logic       w_req_low_next;
  logic       w_req_high_next;

  assign w_eff_low  = r_req_low  | bus.arrive_low;
  assign w_eff_high = r_req_high | bus.arrive_high;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_level_high <= 1'b0;
      r_dir        <= 1'b0;
      r_req_low    <= 1'b0;
      r_req_high   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_level_high <= w_level_next;
      r_dir        <= w_dir_next;
      r_req_low    <= w_req_low_next;
      r_req_high   <= w_req_high_next;
      r_done       <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_level_next = r_level_high;
    w_dir_next   = r_dir;
    w_done_next  = 1'b0;
    w_pick_high  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_eff_low || w_eff_high) begin
          // Prefer the side whose gate already matches the water level.
          w_pick_high  = r_level_high ? w_eff_high : ~w_eff_low;
          w_dir_next   = w_pick_high;
          w_state_next = (w_pick_high == r_level_high) ? S_ENTER : S_PREP_START;
        end
      end
      S_PREP_START: w_state_next = S_PREP_WAIT;
      S_PREP_WAIT: begin
        if (bus.timer_done) begin
          w_level_next = ~r_level_high;
          w_state_next = S_ENTER;
        end
      end
      S_ENTER: begin
        if (bus.boat_in) w_state_next = S_XFER_START;
      end
      S_XFER_START: w_state_next = S_XFER_WAIT;
      S_XFER_WAIT: begin
        if (bus.timer_done) begin
          w_level_next = ~r_level_high;
          w_state_next = S_EXIT;
        end
      end
      S_EXIT: begin
        if (bus.boat_out) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A request is retired when its side enters ENTER; a same-cycle arrival re-arms it.
  assign w_enter         = (w_state_next == S_ENTER) && (r_state != S_ENTER);
  assign w_req_low_next  = (r_req_low  & ~(w_enter & ~w_dir_next)) | bus.arrive_low;
  assign w_req_high_next = (r_req_high & ~(w_enter &  w_dir_next)) | bus.arrive_high;

  always_comb begin
    bus.timer_start    = 1'b0;
    bus.gate_low_open  = 1'b0;
    bus.gate_high_open = 1'b0;
    bus.fill_valve     = 1'b0;
    bus.drain_valve    = 1'b0;
    case (r_state)
      S_PREP_START, S_XFER_START: bus.timer_start = 1'b1;
      S_PREP_WAIT, S_XFER_WAIT: begin
        bus.fill_valve  = ~r_level_high;
        bus.drain_valve =  r_level_high;
      end
      S_ENTER: begin
        bus.gate_low_open  = ~r_dir;
        bus.gate_high_open =  r_dir;
      end
      S_EXIT: begin
        bus.gate_low_open  =  r_dir;
        bus.gate_high_open = ~r_dir;
      end
      default: ;
    endcase
  end

  assign bus.timer_secs = r_level_high ? DRAIN_V : FILL_V;
  assign bus.level_high = r_level_high;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a behavioural countdown timer
// (one count per clock) standing in for the real seconds timer.
module tb_lock_sequencer;
  logic clk;
  logic reset;
  logic force_done;
  logic [9:0] cnt;
  int n_checks;
  int n_fail;

  lock_sequencer_if bus_if();

  lock_sequencer #(.FILL_SECS(3), .DRAIN_SECS(5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) cnt <= 10'd0;
    else if (bus_if.timer_start) cnt <= bus_if.timer_secs;
    else if (cnt != 10'd0) cnt <= cnt - 10'd1;
  end
  assign bus_if.timer_done = force_done | (cnt == 10'd0);

  task automatic clear_inputs();
    bus_if.arrive_low  = 1'b0;
    bus_if.arrive_high = 1'b0;
    bus_if.boat_in     = 1'b0;
    bus_if.boat_out    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Counts consecutive sampled cycles spent in state st (bounded); flags any
  // cycle where valves are wrong for the level, a gate is open or start is high.
  task automatic wait_in(input logic [2:0] st, input logic want_fill, output int n, output logic bad);
    n = 0;
    bad = 1'b0;
    while (bus_if.state == st && n < 50) begin
      if (bus_if.fill_valve !== want_fill || bus_if.drain_valve !== ~want_fill ||
          bus_if.gate_low_open || bus_if.gate_high_open || bus_if.timer_start)
        bad = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    bus_if.arrive_low = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd0 || bus_if.level_high !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: state=%0d level=%0b want 0/0", bus_if.state, bus_if.level_high);
    end
    n_checks++;
    if ({bus_if.gate_low_open, bus_if.gate_high_open, bus_if.fill_valve, bus_if.drain_valve,
         bus_if.timer_start, bus_if.busy, bus_if.done} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0000000", {bus_if.gate_low_open,
        bus_if.gate_high_open, bus_if.fill_valve, bus_if.drain_valve, bus_if.timer_start, bus_if.busy, bus_if.done});
    end
    reset = 1'b1;
    bus_if.arrive_low = 1'b0;
    $display("test_reset complete");
  endtask

  task automatic test_fill_low();
    int n; logic bad;
    do_reset();
    bus_if.arrive_low = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd3 || bus_if.gate_low_open !== 1'b1 || bus_if.gate_high_open !== 1'b0) begin
      n_fail++; $display("FAIL t2_enter: state=%0d gl=%0b gh=%0b want 3/1/0", bus_if.state, bus_if.gate_low_open, bus_if.gate_high_open);
    end
    bus_if.arrive_low = 1'b0;
    bus_if.boat_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd4 || bus_if.timer_start !== 1'b1 || bus_if.timer_secs !== 10'd3) begin
      n_fail++; $display("FAIL t2_xfer_start: state=%0d start=%0b secs=%0d want 4/1/3", bus_if.state, bus_if.timer_start, bus_if.timer_secs);
    end
    bus_if.boat_in = 1'b0;
    @(negedge clk);
    wait_in(3'd5, 1'b1, n, bad);
    n_checks++;
    if (n != 4 || bad) begin
      n_fail++; $display("FAIL t2_fill_wait: cycles=%0d bad=%0b want 4/0", n, bad);
    end
    n_checks++;
    if (bus_if.state !== 3'd6 || bus_if.level_high !== 1'b1 || bus_if.gate_high_open !== 1'b1 || bus_if.gate_low_open !== 1'b0) begin
      n_fail++; $display("FAIL t2_exit: state=%0d level=%0b gh=%0b gl=%0b want 6/1/1/0", bus_if.state, bus_if.level_high, bus_if.gate_high_open, bus_if.gate_low_open);
    end
    bus_if.boat_out = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd0 || bus_if.done !== 1'b1) begin
      n_fail++; $display("FAIL t2_done: state=%0d done=%0b want 0/1", bus_if.state, bus_if.done);
    end
    bus_if.boat_out = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_if.done !== 1'b0) begin
      n_fail++; $display("FAIL t2_done_pulse: done=%0b want 0", bus_if.done);
    end
    $display("test_fill_low complete");
  endtask

  task automatic test_raise_for_high();
    int n; logic bad;
    do_reset();
    bus_if.arrive_high = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd1 || bus_if.timer_start !== 1'b1 || bus_if.timer_secs !== 10'd3 ||
        bus_if.gate_low_open || bus_if.gate_high_open) begin
      n_fail++; $display("FAIL t3_prep_start: state=%0d start=%0b secs=%0d want 1/1/3 gates closed", bus_if.state, bus_if.timer_start, bus_if.timer_secs);
    end
    bus_if.arrive_high = 1'b0;
    @(negedge clk);
    wait_in(3'd2, 1'b1, n, bad);
    n_checks++;
    if (n != 4 || bad) begin
      n_fail++; $display("FAIL t3_prep_wait: cycles=%0d bad=%0b want 4/0", n, bad);
    end
    n_checks++;
    if (bus_if.state !== 3'd3 || bus_if.level_high !== 1'b1 || bus_if.gate_high_open !== 1'b1 || bus_if.gate_low_open !== 1'b0) begin
      n_fail++; $display("FAIL t3_enter_high: state=%0d level=%0b gh=%0b gl=%0b want 3/1/1/0", bus_if.state, bus_if.level_high, bus_if.gate_high_open, bus_if.gate_low_open);
    end
    bus_if.boat_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd4 || bus_if.timer_start !== 1'b1 || bus_if.timer_secs !== 10'd5) begin
      n_fail++; $display("FAIL t3_drain_start: state=%0d start=%0b secs=%0d want 4/1/5", bus_if.state, bus_if.timer_start, bus_if.timer_secs);
    end
    bus_if.boat_in = 1'b0;
    @(negedge clk);
    wait_in(3'd5, 1'b0, n, bad);
    n_checks++;
    if (n != 6 || bad) begin
      n_fail++; $display("FAIL t3_drain_wait: cycles=%0d bad=%0b want 6/0", n, bad);
    end
    n_checks++;
    if (bus_if.state !== 3'd6 || bus_if.level_high !== 1'b0 || bus_if.gate_low_open !== 1'b1 || bus_if.gate_high_open !== 1'b0) begin
      n_fail++; $display("FAIL t3_exit_low: state=%0d level=%0b gl=%0b gh=%0b want 6/0/1/0", bus_if.state, bus_if.level_high, bus_if.gate_low_open, bus_if.gate_high_open);
    end
    bus_if.boat_out = 1'b1;
    @(negedge clk);
    bus_if.boat_out = 1'b0;
    n_checks++;
    if (bus_if.state !== 3'd0 || bus_if.done !== 1'b1) begin
      n_fail++; $display("FAIL t3_done: state=%0d done=%0b want 0/1", bus_if.state, bus_if.done);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd0 || bus_if.busy !== 1'b0) begin
      n_fail++; $display("FAIL t3_stay_idle: state=%0d busy=%0b want 0/0", bus_if.state, bus_if.busy);
    end
    $display("test_raise_for_high complete");
  endtask

  task automatic test_both_arrive();
    int n; logic bad;
    do_reset();
    bus_if.arrive_low = 1'b1;
    bus_if.arrive_high = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd3 || bus_if.gate_low_open !== 1'b1) begin
      n_fail++; $display("FAIL t4_low_first: state=%0d gl=%0b want 3/1", bus_if.state, bus_if.gate_low_open);
    end
    clear_inputs();
    bus_if.boat_in = 1'b1;
    @(negedge clk);
    bus_if.boat_in = 1'b0;
    @(negedge clk);
    wait_in(3'd5, 1'b1, n, bad);
    bus_if.boat_out = 1'b1;
    @(negedge clk);
    bus_if.boat_out = 1'b0;
    n_checks++;
    if (bus_if.state !== 3'd0 || bus_if.done !== 1'b1 || bus_if.level_high !== 1'b1) begin
      n_fail++; $display("FAIL t4_low_done: state=%0d done=%0b level=%0b want 0/1/1", bus_if.state, bus_if.done, bus_if.level_high);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd3 || bus_if.gate_high_open !== 1'b1 || bus_if.gate_low_open !== 1'b0) begin
      n_fail++; $display("FAIL t4_high_direct: state=%0d gh=%0b gl=%0b want 3/1/0", bus_if.state, bus_if.gate_high_open, bus_if.gate_low_open);
    end
    $display("test_both_arrive complete");
  endtask

  task automatic test_reset_abort();
    do_reset();
    bus_if.arrive_low = 1'b1;
    @(negedge clk);
    bus_if.arrive_low = 1'b0;
    bus_if.boat_in = 1'b1;
    @(negedge clk);
    bus_if.boat_in = 1'b0;
    @(negedge clk);
    bus_if.arrive_high = 1'b1;
    @(negedge clk);
    bus_if.arrive_high = 1'b0;
    n_checks++;
    if (bus_if.state !== 3'd5 || bus_if.fill_valve !== 1'b1) begin
      n_fail++; $display("FAIL t5_in_fill: state=%0d fill=%0b want 5/1", bus_if.state, bus_if.fill_valve);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd0 || bus_if.fill_valve || bus_if.drain_valve || bus_if.gate_low_open ||
        bus_if.gate_high_open || bus_if.level_high !== 1'b0) begin
      n_fail++; $display("FAIL t5_abort: state=%0d fv=%0b dv=%0b gl=%0b gh=%0b level=%0b want all 0", bus_if.state,
        bus_if.fill_valve, bus_if.drain_valve, bus_if.gate_low_open, bus_if.gate_high_open, bus_if.level_high);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_if.state !== 3'd0 || bus_if.busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_reqs_cleared: state=%0d busy=%0b want 0/0", bus_if.state, bus_if.busy);
    end
    $display("test_reset_abort complete");
  endtask

  task automatic test_tied_done();
    int exp_st[7] = '{1, 2, 3, 4, 5, 6, 0};
    logic want_start;
    do_reset();
    force_done = 1'b1;
    bus_if.boat_in = 1'b1;
    bus_if.boat_out = 1'b1;
    bus_if.arrive_high = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus_if.arrive_high = 1'b0;
      want_start = (exp_st[i] == 1) || (exp_st[i] == 4);
      n_checks++;
      if (bus_if.state !== 3'(exp_st[i]) || bus_if.timer_start !== want_start) begin
        n_fail++; $display("FAIL t6_step%0d: state=%0d start=%0b want %0d/%0b", i, bus_if.state, bus_if.timer_start, exp_st[i], want_start);
      end
      n_checks++;
      if ((bus_if.gate_low_open && bus_if.gate_high_open) ||
          ((bus_if.fill_valve || bus_if.drain_valve) && (bus_if.gate_low_open || bus_if.gate_high_open))) begin
        n_fail++; $display("FAIL t6_overlap%0d: gl=%0b gh=%0b fv=%0b dv=%0b want no overlap", i,
          bus_if.gate_low_open, bus_if.gate_high_open, bus_if.fill_valve, bus_if.drain_valve);
      end
    end
    n_checks++;
    if (bus_if.level_high !== 1'b0 || bus_if.done !== 1'b1) begin
      n_fail++; $display("FAIL t6_end: level=%0b done=%0b want 0/1", bus_if.level_high, bus_if.done);
    end
    force_done = 1'b0;
    clear_inputs();
    $display("test_tied_done complete");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    force_done = 1'b0;
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_fill_low();
    test_raise_for_high();
    test_both_arrive();
    test_reset_abort();
    test_tied_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
